// File: rtl/ddot_feeder_pkg.sv
// Shared definitions for the dot-product feeder: widths, FSM encoding, element payload.
package ddot_feeder_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LANES   = 4;
  localparam int unsigned BEATS   = 2;
  localparam int unsigned VEC_LEN = LANES * BEATS;
  localparam int unsigned IDX_W   = 3;

  localparam logic [DATA_W-1:0] FP32_ZERO = 32'h0000_0000;

  localparam logic [1:0] ST_FILL        = 2'd0;
  localparam logic [1:0] ST_WAIT_CREDIT = 2'd1;
  localparam logic [1:0] ST_BEAT0       = 2'd2;
  localparam logic [1:0] ST_BEAT1       = 2'd3;

  typedef struct packed {
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
  } elem_pair_t;

endpackage

// File: rtl/ddot_result_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head/valid outputs.
module ddot_result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     valid,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    rd_nxt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             do_push;
  logic             do_pop;

  // Next pointers/count and the head word visible after this cycle (no same-cycle bypass).
  always_comb begin
    do_pop   = pop & valid;
    do_push  = push & ((count != CW'(DEPTH)) | do_pop);
    cnt_nxt  = count + CW'(do_push) - CW'(do_pop);
    rd_nxt   = rd_ptr + AW'(do_pop);
    head_nxt = mem[rd_nxt];
    if (do_push && (wr_ptr == rd_nxt)) head_nxt = din;
    if (cnt_nxt == '0) head_nxt = '0;
  end

  // Storage, pointers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
      dout   <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) mem[wr_ptr] <= din;
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_nxt;
      count  <= cnt_nxt;
      valid  <= (cnt_nxt != '0);
      dout   <= head_nxt;
    end
  end

endmodule

// File: rtl/ddot_feeder.sv
// Packs scalar (x,y) pairs into two 4-lane beats for the dot unit and buffers its results.
module ddot_feeder
  import ddot_feeder_pkg::*;
#(
  parameter int unsigned RES_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_x,
  input  logic [DATA_W-1:0] s_y,
  input  logic              s_last,
  output logic              dd_ready,
  output logic [DATA_W-1:0] dd_x0,
  output logic [DATA_W-1:0] dd_x1,
  output logic [DATA_W-1:0] dd_x2,
  output logic [DATA_W-1:0] dd_x3,
  output logic [DATA_W-1:0] dd_y0,
  output logic [DATA_W-1:0] dd_y1,
  output logic [DATA_W-1:0] dd_y2,
  output logic [DATA_W-1:0] dd_y3,
  input  logic              dd_vld,
  input  logic [DATA_W-1:0] dd_z,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_z,
  output logic              busy,
  output logic              err_unexp
);

  localparam int unsigned CRW = $clog2(RES_DEPTH) + 1;

  logic [1:0]        state, state_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  elem_pair_t        stage [VEC_LEN];
  elem_pair_t        stage_nxt [VEC_LEN];
  logic [CRW-1:0]    credits, credits_nxt;
  logic [CRW-1:0]    outst, outst_nxt;
  logic [CRW-1:0]    fifo_count, fifo_cnt_nxt;
  logic [DATA_W-1:0] lane_x_q [LANES];
  logic [DATA_W-1:0] lane_y_q [LANES];
  logic [DATA_W-1:0] lane_x_nxt [LANES];
  logic [DATA_W-1:0] lane_y_nxt [LANES];
  logic              s_hs, issue, res_push, res_pop, unexp, busy_nxt;

  assign dd_x0 = lane_x_q[0];
  assign dd_x1 = lane_x_q[1];
  assign dd_x2 = lane_x_q[2];
  assign dd_x3 = lane_x_q[3];
  assign dd_y0 = lane_y_q[0];
  assign dd_y1 = lane_y_q[1];
  assign dd_y2 = lane_y_q[2];
  assign dd_y3 = lane_y_q[3];

  // Result buffer; credits guarantee it is never pushed while full.
  ddot_result_fifo #(
    .DEPTH (RES_DEPTH),
    .WIDTH (DATA_W)
  ) u_res_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (res_push),
    .din   (dd_z),
    .pop   (m_ready),
    .valid (m_valid),
    .dout  (m_z),
    .count (fifo_count)
  );

  // Next-state, staging, credit bookkeeping and next values of the registered outputs.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    stage_nxt = stage;
    issue     = 1'b0;
    s_hs      = s_valid & s_ready;

    case (state)
      ST_FILL: begin
        if (s_hs) begin
          stage_nxt[idx] = {s_x, s_y};
          if ((idx == IDX_W'(VEC_LEN - 1)) || s_last) begin
            for (int unsigned i = 0; i < VEC_LEN; i++) begin
              if (i > 32'(idx)) stage_nxt[i] = {FP32_ZERO, FP32_ZERO};
            end
            idx_nxt   = '0;
            state_nxt = (credits != '0) ? ST_BEAT0 : ST_WAIT_CREDIT;
          end else begin
            idx_nxt = idx + IDX_W'(1);
          end
        end
      end
      ST_WAIT_CREDIT: begin
        if (credits != '0) state_nxt = ST_BEAT0;
      end
      ST_BEAT0: begin
        issue     = 1'b1;
        state_nxt = ST_BEAT1;
      end
      ST_BEAT1: begin
        state_nxt = ST_FILL;
        idx_nxt   = '0;
        for (int unsigned i = 0; i < VEC_LEN; i++) stage_nxt[i] = {FP32_ZERO, FP32_ZERO};
      end
      default: state_nxt = ST_FILL;
    endcase

    res_push     = dd_vld & (outst != '0);
    unexp        = dd_vld & (outst == '0);
    res_pop      = m_valid & m_ready;
    credits_nxt  = credits - CRW'(issue) + CRW'(res_pop);
    outst_nxt    = outst + CRW'(issue) - CRW'(res_push);
    fifo_cnt_nxt = fifo_count + CRW'(res_push) - CRW'(res_pop);

    for (int unsigned k = 0; k < LANES; k++) begin
      lane_x_nxt[k] = FP32_ZERO;
      lane_y_nxt[k] = FP32_ZERO;
      if (state_nxt == ST_BEAT0) begin
        lane_x_nxt[k] = stage_nxt[k].x;
        lane_y_nxt[k] = stage_nxt[k].y;
      end else if (state_nxt == ST_BEAT1) begin
        lane_x_nxt[k] = stage_nxt[k + LANES].x;
        lane_y_nxt[k] = stage_nxt[k + LANES].y;
      end
    end

    busy_nxt = (state_nxt != ST_FILL) | (idx_nxt != '0) | (outst_nxt != '0) | (fifo_cnt_nxt != '0);
  end

  // State, staging, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FILL;
      idx       <= '0;
      credits   <= CRW'(RES_DEPTH);
      outst     <= '0;
      s_ready   <= 1'b0;
      dd_ready  <= 1'b0;
      busy      <= 1'b0;
      err_unexp <= 1'b0;
      for (int unsigned i = 0; i < VEC_LEN; i++) stage[i] <= '0;
      for (int unsigned k = 0; k < LANES; k++) begin
        lane_x_q[k] <= '0;
        lane_y_q[k] <= '0;
      end
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      stage     <= stage_nxt;
      credits   <= credits_nxt;
      outst     <= outst_nxt;
      s_ready   <= (state_nxt == ST_FILL);
      dd_ready  <= (state_nxt == ST_BEAT0) | (state_nxt == ST_BEAT1);
      busy      <= busy_nxt;
      err_unexp <= err_unexp | unexp;
      lane_x_q  <= lane_x_nxt;
      lane_y_q  <= lane_y_nxt;
    end
  end

endmodule

// File: tb/tb_ddot_feeder.sv
// Directed bench for ddot_feeder with a behavioural 4-lane dot-unit model.
module tb_ddot_feeder;

  localparam int DL = 4;

  logic        clk, rst;
  logic        s_valid, s_ready, s_last;
  logic [31:0] s_x, s_y;
  logic        dd_ready, dd_vld;
  logic [31:0] dd_x0, dd_x1, dd_x2, dd_x3, dd_y0, dd_y1, dd_y2, dd_y3, dd_z;
  logic        m_valid, m_ready, busy, err_unexp;
  logic [31:0] m_z;

  logic        stub_vld, inj_vld;
  logic [31:0] stub_z, inj_z;
  assign dd_vld = stub_vld | inj_vld;
  assign dd_z   = stub_vld ? stub_z : inj_z;

  ddot_feeder #(.RES_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_y(s_y), .s_last(s_last),
    .dd_ready(dd_ready),
    .dd_x0(dd_x0), .dd_x1(dd_x1), .dd_x2(dd_x2), .dd_x3(dd_x3),
    .dd_y0(dd_y0), .dd_y1(dd_y1), .dd_y2(dd_y2), .dd_y3(dd_y3),
    .dd_vld(dd_vld), .dd_z(dd_z),
    .m_valid(m_valid), .m_ready(m_ready), .m_z(m_z),
    .busy(busy), .err_unexp(err_unexp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [3:0]       n;
    logic [7:0][31:0] x;
    logic [7:0][31:0] y;
    logic [31:0]      exp_z;
  } vec_t;

  vec_t        tbl [6];
  int          n_tests, n_fail;
  int          cyc, run, beats_total, viol;
  real         acc, beat_sum;
  logic [31:0] b1_x0, b1_y3;
  logic [31:0] q_z [$];
  int          q_due [$];

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] d;
    if (f[30:23] == 8'd0) return 0.0;
    d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return 32'd0;
    d = $realtobits(r);
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  // Dot-unit model plus beat-protocol monitor, evaluated away from the active edge.
  initial begin
    stub_vld = 1'b0; stub_z = '0; run = 0; beats_total = 0; viol = 0; cyc = 0;
    acc = 0.0; b1_x0 = '0; b1_y3 = '0;
    forever begin
      @(negedge clk);
      cyc++;
      stub_vld = 1'b0;
      stub_z   = '0;
      if (rst) begin
        q_z.delete();
        q_due.delete();
        run = 0;
      end else begin
        if (q_due.size() > 0 && q_due[0] <= cyc) begin
          stub_vld = 1'b1;
          stub_z   = q_z.pop_front();
          void'(q_due.pop_front());
        end
        if (dd_ready) begin
          run++;
          beats_total++;
          beat_sum = f2r(dd_x0) * f2r(dd_y0) + f2r(dd_x1) * f2r(dd_y1)
                   + f2r(dd_x2) * f2r(dd_y2) + f2r(dd_x3) * f2r(dd_y3);
          if (run == 1) acc = beat_sum;
          else if (run == 2) begin
            acc   = acc + beat_sum;
            b1_x0 = dd_x0;
            b1_y3 = dd_y3;
            q_z.push_back(r2f(acc));
            q_due.push_back(cyc + DL);
          end else viol++;
        end else begin
          if (run == 1) viol++;
          run = 0;
          if ((dd_x0 | dd_x1 | dd_x2 | dd_x3 | dd_y0 | dd_y1 | dd_y2 | dd_y3) != 32'd0) viol++;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_elem(input logic [31:0] x, input logic [31:0] y, input logic last);
    int n;
    s_valid = 1'b1; s_x = x; s_y = y; s_last = last;
    n = 0;
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) check("send_accept", 32'(s_ready), 32'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_vec(input int v);
    for (int k = 0; k < int'(tbl[v].n); k++)
      send_elem(tbl[v].x[k], tbl[v].y[k], k == int'(tbl[v].n) - 1);
  endtask

  task automatic get_result(input string name, input logic [31:0] exp);
    int n;
    n = 0;
    while (!m_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, 32'(m_valid), 32'd1);
    check(name, m_z, exp);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  task automatic wait_beats(input int target);
    int n;
    n = 0;
    while (beats_total < target && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("beat_count", 32'(beats_total), 32'(target));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 32'd0);
    check("rst_dd_ready", 32'(dd_ready), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_z", m_z, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_unexp), 32'd0);
    check("rst_lane", dd_x0 | dd_y3, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready), 32'd1);
  endtask

  logic [31:0] ints [8] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                            32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000};
  int b0;

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0; s_last = 1'b0;
    m_ready = 1'b0; inj_vld = 1'b0; inj_z = '0;

    for (int v = 0; v < 6; v++) tbl[v] = '0;
    tbl[0].n = 4'd8; tbl[0].exp_z = 32'h41800000;
    for (int k = 0; k < 8; k++) begin tbl[0].x[k] = 32'h3F800000; tbl[0].y[k] = 32'h40000000; end
    tbl[1].n = 4'd3; tbl[1].exp_z = 32'h40C00000;
    for (int k = 0; k < 3; k++) begin tbl[1].x[k] = ints[k]; tbl[1].y[k] = 32'h3F800000; end
    tbl[2].n = 4'd1; tbl[2].exp_z = 32'h41400000;
    tbl[2].x[0] = 32'h40400000; tbl[2].y[0] = 32'h40800000;
    tbl[3].n = 4'd8; tbl[3].exp_z = 32'h42100000;
    for (int k = 0; k < 8; k++) begin tbl[3].x[k] = ints[k]; tbl[3].y[k] = 32'h3F800000; end
    tbl[4].n = 4'd5; tbl[4].exp_z = 32'hC1700000;
    for (int k = 0; k < 5; k++) begin tbl[4].x[k] = 32'h40000000; tbl[4].y[k] = 32'hBFC00000; end
    tbl[5].n = 4'd4; tbl[5].exp_z = 32'h41800000;
    for (int k = 0; k < 4; k++) begin tbl[5].x[k] = 32'h3F000000; tbl[5].y[k] = 32'h41000000; end

    do_reset();

    // Table: one vector at a time, result value, beat-1 lane contents and idle busy.
    for (int v = 0; v < 6; v++) begin
      send_vec(v);
      get_result($sformatf("vec%0d_z", v), tbl[v].exp_z);
      check($sformatf("vec%0d_b1_x0", v), b1_x0, (tbl[v].n > 4) ? tbl[v].x[4] : 32'd0);
      check($sformatf("vec%0d_b1_y3", v), b1_y3, (tbl[v].n > 7) ? tbl[v].y[7] : 32'd0);
      check($sformatf("vec%0d_busy", v), 32'(busy), 32'd0);
    end

    // Credit exhaustion: fifth vector waits until one result is drained.
    b0 = beats_total;
    for (int v = 0; v < 5; v++) send_vec(v);
    repeat (20) @(negedge clk);
    check("stall_s_ready", 32'(s_ready), 32'd0);
    check("stall_beats", 32'(beats_total - b0), 32'd8);
    check("stall_m_valid", 32'(m_valid), 32'd1);
    check("stall_busy", 32'(busy), 32'd1);
    get_result("stall_res0", tbl[0].exp_z);
    wait_beats(b0 + 10);
    for (int v = 1; v < 5; v++) get_result($sformatf("stall_res%0d", v), tbl[v].exp_z);

    // Back-to-back issue with concurrent drain; results must keep issue order.
    fork
      begin
        for (int v = 3; v < 6; v++) send_vec(v);
      end
      begin
        for (int v = 3; v < 6; v++) get_result($sformatf("b2b_res%0d", v), tbl[v].exp_z);
      end
    join
    repeat (2) @(negedge clk);
    check("b2b_busy", 32'(busy), 32'd0);

    // Result with nothing outstanding is dropped and flagged.
    inj_vld = 1'b1; inj_z = 32'hDEADBEEF;
    @(negedge clk);
    inj_vld = 1'b0;
    check("unexp_err", 32'(err_unexp), 32'd1);
    check("unexp_m_valid", 32'(m_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("unexp_m_valid_later", 32'(m_valid), 32'd0);
    check("unexp_err_sticky", 32'(err_unexp), 32'd1);

    // Reset in the middle of filling a vector.
    for (int k = 0; k < 3; k++) send_elem(tbl[3].x[k], tbl[3].y[k], 1'b0);
    do_reset();
    send_vec(0);
    get_result("midfill_res", tbl[0].exp_z);

    // Reset while a vector is in flight inside the dot unit.
    b0 = beats_total;
    send_vec(1);
    wait_beats(b0 + 2);
    do_reset();
    repeat (10) @(negedge clk);
    check("midflight_m_valid", 32'(m_valid), 32'd0);
    check("midflight_err", 32'(err_unexp), 32'd0);

    // Credits are back to full: four vectors issue without draining.
    b0 = beats_total;
    for (int v = 0; v < 4; v++) send_vec(v);
    repeat (20) @(negedge clk);
    check("credits_full_beats", 32'(beats_total - b0), 32'd8);
    check("credits_full_s_ready", 32'(s_ready), 32'd1);
    for (int v = 0; v < 4; v++) get_result($sformatf("credits_res%0d", v), tbl[v].exp_z);
    send_vec(2);
    get_result("after_refill_res", tbl[2].exp_z);

    check("beat_protocol", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
